// File: rtl/mc_mem_bridge_if.sv
// Bus bundle for mc_mem_bridge: upstream request/response side
// and downstream quadword memory side.
interface mc_mem_bridge_if;
    logic        ACT;
    logic        CMD;
    logic [1:0]  SIZE;
    logic [44:0] ADDRESS;
    logic [31:0] DTo;
    logic        NEXT;
    logic        DRDY;
    logic [31:0] DTi;
    logic        MACT;
    logic        MCMD;
    logic [41:0] MADDR;
    logic [7:0]  MBE;
    logic [63:0] MDTo;
    logic        MNEXT;
    logic        MDRDY;
    logic [63:0] MDTi;

    modport slave (
        input  ACT, CMD, SIZE, ADDRESS, DTo, MNEXT, MDRDY, MDTi,
        output NEXT, DRDY, DTi, MACT, MCMD, MADDR, MBE, MDTo
    );

    modport master (
        output ACT, CMD, SIZE, ADDRESS, DTo, MNEXT, MDRDY, MDTi,
        input  NEXT, DRDY, DTi, MACT, MCMD, MADDR, MBE, MDTo
    );
endinterface

// File: rtl/mc_mem_bridge.sv
// Narrow (8/16/32-bit) request to 64-bit quadword memory bridge
// with in-order request queue and outstanding-read tracking.
module mc_mem_bridge #(
    parameter int QDEPTH = 2,
    parameter int RDEPTH = 4
) (
    input logic            CLK,
    input logic            RESET,
    mc_mem_bridge_if.slave bus
);
    localparam int QAW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
    localparam int RAW = (RDEPTH > 1) ? $clog2(RDEPTH) : 1;
    localparam int CW  = $clog2(RDEPTH + 1);

    logic [QAW:0]   q_wr, q_rd;
    logic [QAW-1:0] q_wi, q_ri;
    logic           q_cmd  [QDEPTH];
    logic [41:0]    q_addr [QDEPTH];
    logic [7:0]     q_be   [QDEPTH];
    logic [63:0]    q_data [QDEPTH];
    logic [2:0]     q_lane [QDEPTH];
    logic [1:0]     q_size [QDEPTH];

    logic [RAW:0]   t_wr, t_rd;
    logic [RAW-1:0] t_wi, t_ri;
    logic [2:0]     t_lane [RDEPTH];
    logic [1:0]     t_size [RDEPTH];

    logic [CW-1:0]  cnt;
    logic           q_empty, q_full, push, pop, mact;
    logic           rd_issue, rd_ret;
    logic           ERR_SPUR;
    logic [2:0]     lane;
    logic [7:0]     be;
    logic [63:0]    wdata;
    logic [63:0]    shifted;
    logic [31:0]    rdata;
    logic           drdy_q;
    logic [31:0]    dti_q;

    // Wrap index at depth and flip the extra lap bit.
    function automatic logic [QAW:0] q_inc(input logic [QAW:0] p);
        if (p[QAW-1:0] == QAW'(QDEPTH - 1))
            return {~p[QAW], {QAW{1'b0}}};
        return p + {{QAW{1'b0}}, 1'b1};
    endfunction

    function automatic logic [RAW:0] t_inc(input logic [RAW:0] p);
        if (p[RAW-1:0] == RAW'(RDEPTH - 1))
            return {~p[RAW], {RAW{1'b0}}};
        return p + {{RAW{1'b0}}, 1'b1};
    endfunction

    assign q_wi    = q_wr[QAW-1:0];
    assign q_ri    = q_rd[QAW-1:0];
    assign t_wi    = t_wr[RAW-1:0];
    assign t_ri    = t_rd[RAW-1:0];
    assign q_empty = (q_wr == q_rd);
    assign q_full  = (q_wi == q_ri) && (q_wr[QAW] != q_rd[QAW]);

    assign push     = bus.ACT & ~q_full;
    assign mact     = ~q_empty & (~q_cmd[q_ri] | (cnt < CW'(RDEPTH)));
    assign pop      = mact & bus.MNEXT;
    assign rd_issue = pop & q_cmd[q_ri];
    assign rd_ret   = bus.MDRDY & (cnt != '0);

    assign bus.NEXT  = push;
    assign bus.MACT  = mact;
    assign bus.MCMD  = ~q_empty & q_cmd[q_ri];
    assign bus.MADDR = q_empty ? '0 : q_addr[q_ri];
    assign bus.MBE   = q_empty ? '0 : q_be[q_ri];
    assign bus.MDTo  = q_empty ? '0 : q_data[q_ri];
    assign bus.DRDY  = drdy_q;
    assign bus.DTi   = dti_q;

    always_comb begin
        lane  = bus.ADDRESS[2:0];
        be    = '0;
        wdata = '0;
        unique case (1'b1)
            (bus.SIZE == 2'b00): begin
                lane  = bus.ADDRESS[2:0];
                be    = 8'h01 << lane;
                wdata = {8{bus.DTo[7:0]}};
            end
            (bus.SIZE == 2'b01): begin
                lane  = {bus.ADDRESS[2:1], 1'b0};
                be    = 8'h03 << lane;
                wdata = {4{bus.DTo[15:0]}};
            end
            bus.SIZE[1]: begin
                lane  = {bus.ADDRESS[2], 2'b00};
                be    = 8'h0F << lane;
                wdata = {2{bus.DTo}};
            end
        endcase
    end

    always_comb begin
        shifted = bus.MDTi >> {t_lane[t_ri], 3'b000};
        rdata   = '0;
        unique case (1'b1)
            (t_size[t_ri] == 2'b00): rdata = {24'b0, shifted[7:0]};
            (t_size[t_ri] == 2'b01): rdata = {16'b0, shifted[15:0]};
            t_size[t_ri][1]:         rdata = shifted[31:0];
        endcase
    end

    always_ff @(posedge CLK) begin
        if (push) begin
            q_cmd[q_wi]  <= bus.CMD;
            q_addr[q_wi] <= bus.ADDRESS[44:3];
            q_be[q_wi]   <= be;
            q_data[q_wi] <= wdata;
            q_lane[q_wi] <= lane;
            q_size[q_wi] <= bus.SIZE;
        end
        if (rd_issue) begin
            t_lane[t_wi] <= q_lane[q_ri];
            t_size[t_wi] <= q_size[q_ri];
        end
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            q_wr     <= '0;
            q_rd     <= '0;
            t_wr     <= '0;
            t_rd     <= '0;
            cnt      <= '0;
            ERR_SPUR <= 1'b0;
            drdy_q   <= 1'b0;
            dti_q    <= '0;
        end else begin
            if (push)     q_wr <= q_inc(q_wr);
            if (pop)      q_rd <= q_inc(q_rd);
            if (rd_issue) t_wr <= t_inc(t_wr);
            if (rd_ret)   t_rd <= t_inc(t_rd);
            if (rd_issue && !rd_ret)
                cnt <= cnt + CW'(1);
            else if (!rd_issue && rd_ret)
                cnt <= cnt - CW'(1);
            if (bus.MDRDY && cnt == '0)
                ERR_SPUR <= 1'b1;
            drdy_q <= rd_ret;
            if (rd_ret)
                dti_q <= rdata;
        end
    end
endmodule

// File: tb/tb_mc_mem_bridge.sv
// Randomized scoreboard bench for mc_mem_bridge with directed
// alignment, backpressure, read-limit and reset scenarios.
module tb_mc_mem_bridge;
    localparam int QDEPTH = 2;
    localparam int RDEPTH = 4;

    logic CLK   = 1'b0;
    logic RESET = 1'b0;

    mc_mem_bridge_if bus ();

    mc_mem_bridge #(
        .QDEPTH(QDEPTH),
        .RDEPTH(RDEPTH)
    ) dut (
        .CLK  (CLK),
        .RESET(RESET),
        .bus  (bus)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        bit          cmd;
        logic [41:0] addr;
        logic [7:0]  be;
        logic [63:0] data;
        int          lane;
        int          n;
    } req_t;

    req_t        exp_req[$];
    req_t        rd_info[$];
    req_t        r_m;
    int          total = 0;
    int          bad = 0;
    int          acc_cnt = 0;
    bit          drdy_due = 0;
    logic [31:0] pend_dti;
    logic [31:0] exp_dti = '0;
    bit          stall_prev = 0;
    logic [50:0] head_p;
    logic [63:0] data_p;
    bit          exp_next, exp_mact;
    int          mnext_mode = 0;
    bit          resp_auto = 0;
    bit          man_pulse = 0;
    logic [63:0] man_data = '0;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // Reference: lane from natural alignment, enables and replicated data.
    function automatic req_t model(input bit c, input logic [1:0] s,
                                   input logic [44:0] a,
                                   input logic [31:0] d);
        req_t r;
        int   n;
        n      = (s == 2'b00) ? 1 : (s == 2'b01) ? 2 : 4;
        r.cmd  = c;
        r.n    = n;
        r.lane = (int'(a % 8) / n) * n;
        r.addr = 42'(a >> 3);
        r.be   = '0;
        r.data = '0;
        for (int i = 0; i < n; i++) r.be[r.lane + i] = 1'b1;
        for (int i = 0; i < 8; i++) r.data[8*i +: 8] = d[8*(i % n) +: 8];
        return r;
    endfunction

    function automatic logic [31:0] extract(input req_t r,
                                            input logic [63:0] m);
        logic [31:0] v;
        v = '0;
        for (int k = 0; k < r.n; k++) v[8*k +: 8] = m[8*(r.lane + k) +: 8];
        return v;
    endfunction

    always @(posedge CLK) begin
        #1;
        case (mnext_mode)
            0:       bus.MNEXT = 1'b0;
            1:       bus.MNEXT = 1'b1;
            default: bus.MNEXT = 1'($urandom_range(0, 1));
        endcase
        if (man_pulse) begin
            bus.MDRDY = 1'b1;
            bus.MDTi  = man_data;
            man_pulse = 0;
        end else if (resp_auto && rd_info.size() > 0
                     && $urandom_range(0, 2) == 0) begin
            bus.MDRDY = 1'b1;
            bus.MDTi  = {$urandom, $urandom};
        end else begin
            bus.MDRDY = 1'b0;
        end
    end

    always @(negedge CLK) begin
        if (RESET) begin
            exp_next = bus.ACT && (exp_req.size() < QDEPTH);
            chk("next", 64'(bus.NEXT), 64'(exp_next));
            chk("drdy", 64'(bus.DRDY), 64'(drdy_due));
            if (drdy_due) exp_dti = pend_dti;
            chk("dti", 64'(bus.DTi), 64'(exp_dti));
            drdy_due = 0;
            exp_mact = exp_req.size() > 0 &&
                       (!exp_req[0].cmd || rd_info.size() < RDEPTH);
            chk("mact", 64'(bus.MACT), 64'(exp_mact));
            if (stall_prev) begin
                chk("hold_head", 64'({bus.MCMD, bus.MADDR, bus.MBE}),
                    64'(head_p));
                chk("hold_data", bus.MDTo, data_p);
            end
            if (bus.MACT && exp_req.size() > 0) begin
                chk("mcmd", 64'(bus.MCMD), 64'(exp_req[0].cmd));
                chk("maddr", 64'(bus.MADDR), 64'(exp_req[0].addr));
                chk("mbe", 64'(bus.MBE), 64'(exp_req[0].be));
                if (!exp_req[0].cmd)
                    chk("mdto", bus.MDTo, exp_req[0].data);
            end
            if (bus.MDRDY && rd_info.size() > 0) begin
                r_m      = rd_info.pop_front();
                pend_dti = extract(r_m, bus.MDTi);
                drdy_due = 1;
            end
            if (bus.MACT && bus.MNEXT && exp_req.size() > 0) begin
                r_m = exp_req.pop_front();
                if (r_m.cmd) rd_info.push_back(r_m);
            end
            stall_prev = bus.MACT && !bus.MNEXT;
            head_p     = {bus.MCMD, bus.MADDR, bus.MBE};
            data_p     = bus.MDTo;
            if (bus.ACT && bus.NEXT) begin
                exp_req.push_back(model(bus.CMD, bus.SIZE, bus.ADDRESS,
                                        bus.DTo));
                acc_cnt++;
            end
        end
    end

    task automatic tick();
        @(posedge CLK);
        #2;
    endtask

    task automatic send(input bit c, input logic [1:0] s,
                        input logic [44:0] a, input logic [31:0] d);
        int  waited;
        bit  got;
        bus.ACT     = 1'b1;
        bus.CMD     = c;
        bus.SIZE    = s;
        bus.ADDRESS = a;
        bus.DTo     = d;
        waited      = 0;
        got         = 0;
        while (!got && waited < 200) begin
            @(negedge CLK);
            got = bus.NEXT;
            waited++;
        end
        if (!got) chk("send_timeout", 64'(bus.NEXT), 64'd1);
        tick();
        bus.ACT = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((exp_req.size() > 0 || rd_info.size() > 0 || drdy_due)
               && n < 3000) begin
            tick();
            n++;
        end
        chk("drain_left", 64'(exp_req.size() + rd_info.size()), 64'd0);
    endtask

    task automatic reset_checks(input string tag);
        chk({tag, "_next"}, 64'(bus.NEXT), 64'd0);
        chk({tag, "_mact"}, 64'(bus.MACT), 64'd0);
        chk({tag, "_drdy"}, 64'(bus.DRDY), 64'd0);
        chk({tag, "_dti"}, 64'(bus.DTi), 64'd0);
        chk({tag, "_mbe"}, 64'(bus.MBE), 64'd0);
        chk({tag, "_mdto"}, bus.MDTo, 64'd0);
        chk({tag, "_maddr"}, 64'(bus.MADDR), 64'd0);
        chk({tag, "_mcmd"}, 64'(bus.MCMD), 64'd0);
        chk({tag, "_spur"}, 64'(dut.ERR_SPUR), 64'd0);
    endtask

    initial begin
        bus.ACT     = 1'b0;
        bus.CMD     = 1'b0;
        bus.SIZE    = 2'b00;
        bus.ADDRESS = '0;
        bus.DTo     = '0;
        #3;
        reset_checks("rst");
        repeat (3) tick();
        RESET = 1'b1;
        tick();

        // byte read at lane 5
        send(1'b1, 2'b00, 45'h5, 32'h0);
        @(negedge CLK);
        chk("req024_mbe", 64'(bus.MBE), 64'h20);
        tick();
        mnext_mode = 1;
        repeat (3) tick();
        man_data  = 64'h8877665544332211;
        man_pulse = 1;
        tick();
        tick();
        @(negedge CLK);
        chk("req024_drdy", 64'(bus.DRDY), 64'd1);
        chk("req024_dti", 64'(bus.DTi), 64'h66);
        tick();

        // 32-bit write at offset 6 held off the bus
        mnext_mode = 0;
        send(1'b0, 2'b10, 45'h123456789AB6, 32'hAABBCCDD);
        @(negedge CLK);
        chk("req025_mbe", 64'(bus.MBE), 64'hF0);
        chk("req025_mdto", bus.MDTo, 64'hAABBCCDDAABBCCDD);
        chk("req025_maddr", 64'(bus.MADDR), 64'h2468ACF1356);
        tick();
        mnext_mode = 1;
        drain();

        // three back-to-back requests against a stalled port
        mnext_mode = 0;
        tick();
        begin
            int start;
            start = acc_cnt;
            fork
                begin
                    send(1'b0, 2'b00, 45'h11, 32'h5A);
                    send(1'b1, 2'b01, 45'h22, 32'h0);
                    send(1'b0, 2'b10, 45'h35, 32'h01020304);
                end
                begin
                    repeat (5) tick();
                    chk("req026_accepts", 64'(acc_cnt - start), 64'd2);
                    mnext_mode = 1;
                end
            join
        end
        resp_auto = 1;
        drain();

        // read limit: fifth read waits for a return
        resp_auto  = 0;
        mnext_mode = 1;
        tick();
        for (int i = 0; i < 5; i++)
            send(1'b1, 2'($urandom_range(0, 3)), 45'($urandom), 32'h0);
        repeat (3) tick();
        @(negedge CLK);
        chk("req027_stall", 64'(bus.MACT), 64'd0);
        man_data  = {$urandom, $urandom};
        man_pulse = 1;
        tick();
        tick();
        @(negedge CLK);
        chk("req027_resume", 64'(bus.MACT), 64'd1);
        tick();
        resp_auto = 1;
        drain();

        // random traffic
        mnext_mode = 2;
        for (int i = 0; i < 250; i++) begin
            repeat ($urandom_range(0, 2)) tick();
            send(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                 {13'($urandom), $urandom}, $urandom);
        end
        mnext_mode = 1;
        drain();

        // reset with two outstanding and two queued
        resp_auto  = 0;
        mnext_mode = 1;
        tick();
        send(1'b1, 2'b00, 45'h101, 32'h0);
        send(1'b1, 2'b01, 45'h202, 32'h0);
        repeat (2) tick();
        mnext_mode = 0;
        send(1'b1, 2'b10, 45'h304, 32'h0);
        send(1'b0, 2'b00, 45'h407, 32'h77);
        tick();
        bus.ACT = 1'b0;
        RESET   = 1'b0;
        #1;
        reset_checks("midrst");
        exp_req.delete();
        rd_info.delete();
        drdy_due   = 0;
        stall_prev = 0;
        exp_dti    = '0;
        repeat (2) tick();
        RESET = 1'b1;
        tick();
        man_data  = 64'hFFEEDDCCBBAA9988;
        man_pulse = 1;
        repeat (3) tick();
        @(negedge CLK);
        chk("req029_no_drdy", 64'(bus.DRDY), 64'd0);
        chk("req029_dti", 64'(bus.DTi), 64'd0);
        chk("req029_spur", 64'(dut.ERR_SPUR), 64'd1);
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/mc_mem_bridge.md
MC_MEM_BRIDGE -- requirements
Module: mc_mem_bridge

Interface
REQ-001 SHALL have parameters: QDEPTH, default 2, request queue entries (2 or 4); RDEPTH, default 4, maximum outstanding reads (1..8).
REQ-002 SHALL have ports, clock and reset first:
- CLK  in  1  single clock; all state on posedge.
- RESET  in  1  asynchronous, active-low reset.
- ACT  in  1  upstream request valid.
- CMD  in  1  1 = read, 0 = write.
- SIZE  in  2  00 = byte, 01 = 16-bit, 10 = 32-bit, 11 = 32-bit.
- ADDRESS  in  45  byte address.
- DTo  in  32  write data, right-aligned.
- NEXT  out  1  request accepted this cycle.
- DRDY  out  1  read data valid, one-cycle pulse.
- DTi  out  32  read data, right-aligned, zero-extended.
- MACT  out  1  downstream request valid.
- MCMD  out  1  1 = read, 0 = write.
- MADDR  out  42  quadword address, ADDRESS[44:3].
- MBE  out  8  byte enables.
- MDTo  out  64  write data.
- MNEXT  in  1  downstream accepts the current request.
- MDRDY  in  1  downstream read data valid.
- MDTi  in  64  downstream read data.

Function
REQ-003 SHALL accept an upstream request when ACT=1 and the request queue is not full.
REQ-004 SHALL drive NEXT combinationally as ACT & ~queue_full.
REQ-005 SHALL make an accepted request visible on MACT no earlier than the next cycle; there is no combinational ACT->MACT path.
REQ-006 SHALL align addresses by size: byte uses ADDRESS[2:0]; 16-bit ignores ADDRESS[0]; 32-bit ignores ADDRESS[1:0]. Lane offset L = aligned ADDRESS[2:0].
REQ-007 SHALL generate MBE as: byte 8'b1<<L; 16-bit 8'b11<<L; 32-bit 8'b1111<<L.
REQ-008 SHALL drive MDTo as DTo[7:0] replicated x8 (byte), DTo[15:0] x4 (16-bit), or DTo x2 (32-bit).
REQ-009 SHALL drive MACT=1 when the queue head is valid and (head is a write, or outstanding reads < RDEPTH).
REQ-010 SHALL hold MACT, MCMD, MADDR, MBE and MDTo stable until MNEXT=1.
REQ-011 SHALL pop the queue head in the cycle MACT & MNEXT.
REQ-012 SHALL issue requests in strict acceptance order; a stalled read blocks the writes behind it.
REQ-013 SHALL push {L, SIZE} into a read-tracking FIFO (depth RDEPTH) when a read is issued (MACT & MNEXT & MCMD).
REQ-014 SHALL treat MDRDY as returning in issue order; on MDRDY, pop the tracking FIFO head.
REQ-015 SHALL, on MDRDY, extract bytes [L+n-1:L] of MDTi (n = 1, 2 or 4), zero-extend them, and register the result to DTi.
REQ-016 SHALL pulse DRDY=1 in the cycle after MDRDY (latency 1 cycle).
REQ-017 SHALL hold DTi between DRDY pulses.
REQ-018 SHALL keep the outstanding-read counter in the range 0..RDEPTH:
- increment on read issue;
- decrement on MDRDY;
- hold if both occur in the same cycle.
REQ-019 SHALL accept push and pop of the request queue in the same cycle when full; NEXT still follows REQ-004 (stays 0 while full).
REQ-020 SHALL ignore MDRDY while no read is outstanding: no DRDY, no state change; error flag ERR_SPUR (internal, observable in simulation) set sticky.
REQ-021 SHALL use circular pointers for all FIFOs, wrapping at depth; full/empty use one extra pointer bit.

Reset
REQ-022 SHALL, on RESET=0 (asynchronous, active-low), clear both queues, the outstanding counter and ERR_SPUR, and drive:
- NEXT=0 (ACT=0) combinationally;
- MACT=0, DRDY=0, DTi=0, MBE=0, MDTo=0, MADDR=0, MCMD=0.
REQ-023 SHALL discard, on reset mid-transaction, all pending requests and in-flight reads; MDRDY arriving after reset release is treated per REQ-020.

Verification
REQ-024 Byte read: ADDRESS=0x...0005, SIZE=00, CMD=1; MDTi=0x8877665544332211 -> MBE=0x20, DTi=0x00000066, DRDY 1 cycle after MDRDY.
REQ-025 32-bit write: ADDRESS=0x...0006, SIZE=10, DTo=0xAABBCCDD -> MBE=0xF0, MDTo=0xAABBCCDDAABBCCDD, MADDR=ADDRESS[44:3].
REQ-026 Backpressure: MNEXT=0 for 5 cycles, 3 back-to-back ACT -> NEXT=1 for 2 requests then 0; outputs stable; all 3 issued in order once MNEXT=1.
REQ-027 Read limit: RDEPTH=4, 5 reads, no MDRDY -> MACT drops after the 4th issue; one MDRDY -> 5th issues the next cycle.
REQ-028 Ordering: read, write, read to distinct lanes, MDRDY returned twice -> DTi values match the first then third request lanes.
REQ-029 Reset mid-flight: RESET=0 with 2 queued and 2 outstanding -> all outputs per REQ-022; a subsequent MDRDY produces no DRDY.
